// File: rtl/block_avg_decimator.sv
// Block-averaging decimator: sums 2**n signed samples per block and emits the
// floor average plus block min/max, held under a sticky valid/ack handshake.
module block_avg_decimator #(
    parameter int R    = 14,
    parameter int NT   = 5,
    parameter int NMAX = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [NT-1:0] n,
    input  logic [R-1:0]  in,
    input  logic          ack,
    output logic [R-1:0]  out,
    output logic [R-1:0]  out_min,
    output logic [R-1:0]  out_max,
    output logic          valid,
    output logic          overrun,
    output logic          busy
);

    localparam int A = R + NMAX;

    logic [NMAX-1:0]        cnt_r;
    logic signed [A-1:0]    acc_r;
    logic signed [R-1:0]    min_r;
    logic signed [R-1:0]    max_r;
    logic [NT-1:0]          nl_r;
    logic [R-1:0]           out_r;
    logic [R-1:0]           out_min_r;
    logic [R-1:0]           out_max_r;
    logic                   valid_r;
    logic                   overrun_r;
    logic                   busy_r;

    logic                   start_s;
    logic                   last_s;
    logic [NT-1:0]          n_sat_s;
    logic [NT-1:0]          nl_eff_s;
    logic [NMAX-1:0]        last_cnt_s;
    logic signed [R-1:0]    in_s;
    logic signed [R-1:0]    min_next_s;
    logic signed [R-1:0]    max_next_s;
    logic signed [A-1:0]    acc_base_s;
    logic signed [A-1:0]    sum_s;
    logic signed [R-1:0]    avg_s;

    // Next-sample arithmetic: a new block seeds from the incoming sample, never from stale state
    always_comb begin
        in_s    = $signed(in);
        start_s = (cnt_r == {NMAX{1'b0}});

        if (n > NT'(NMAX)) begin
            n_sat_s = NT'(NMAX);
        end else begin
            n_sat_s = n;
        end

        if (start_s) begin
            nl_eff_s   = n_sat_s;
            acc_base_s = {A{1'b0}};
            min_next_s = in_s;
            max_next_s = in_s;
        end else begin
            nl_eff_s   = nl_r;
            acc_base_s = acc_r;
            min_next_s = (in_s < min_r) ? in_s : min_r;
            max_next_s = (in_s > max_r) ? in_s : max_r;
        end

        // Low nl bits set: the count value of the final sample in the block
        last_cnt_s = ~({NMAX{1'b1}} << nl_eff_s);
        last_s     = (cnt_r == last_cnt_s);
        sum_s      = acc_base_s + {{NMAX{in_s[R-1]}}, in_s};
        avg_s      = R'(sum_s >>> nl_eff_s);
    end

    // Block accumulation state: counter, accumulator, running min/max, latched exponent
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {NMAX{1'b0}};
            acc_r  <= {A{1'b0}};
            min_r  <= {R{1'b0}};
            max_r  <= {R{1'b0}};
            nl_r   <= {NT{1'b0}};
            busy_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= {NMAX{1'b0}};
            acc_r  <= {A{1'b0}};
            busy_r <= 1'b0;
        end else if (last_s) begin
            cnt_r  <= {NMAX{1'b0}};
            acc_r  <= {A{1'b0}};
            nl_r   <= nl_eff_s;
            busy_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_r + NMAX'(1);
            acc_r  <= sum_s;
            min_r  <= min_next_s;
            max_r  <= max_next_s;
            nl_r   <= nl_eff_s;
            busy_r <= 1'b1;
        end
    end

    // Result registers and valid/overrun handshake; latest completed block wins
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r     <= {R{1'b0}};
            out_min_r <= {R{1'b0}};
            out_max_r <= {R{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else if (en && last_s) begin
            out_r     <= avg_s;
            out_min_r <= min_next_s;
            out_max_r <= max_next_s;
            valid_r   <= 1'b1;
            overrun_r <= ack ? 1'b0 : (valid_r | overrun_r);
        end else if (ack) begin
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            valid_r   <= valid_r;
            overrun_r <= overrun_r;
        end
    end

    assign out     = out_r;
    assign out_min = out_min_r;
    assign out_max = out_max_r;
    assign valid   = valid_r;
    assign overrun = overrun_r;
    assign busy    = busy_r;

endmodule
